fetch_unit_q: RTL
=================

Name: fetch_unit_q

Overview:
Parametrised instruction-fetch stage with a configurable 2-bit-counter branch history table (BHT) and a decoupling fetch queue (FQ) towards the dispatcher. Each cycle it presents pc to the instruction cache. On a hit it predicts the next pc (JAL, B-type, JALR handling) and enqueues {ins, pc, pred_taken}. The ROB redirects it via clear/new_pc and trains the BHT via resolved-branch updates.

Parameters:
BHT_IDX_W, 5, BHT index width; table has 2^BHT_IDX_W entries, index = pc[BHT_IDX_W+1:2]
FQ_DEPTH_LOG, 3, FQ holds 2^FQ_DEPTH_LOG entries
BHT_INIT, 2'b10, counter reset value (weakly taken)
RESET_PC, 32'h0, pc after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; 0 freezes all state
hit  in  1  icache holds the word at addr_to_icache this cycle
ins  in  32  instruction word, valid when hit
addr_to_icache  out  32  current pc (combinational from pc register)
fq_valid  out  1  FQ head valid
fq_ready  in  1  dispatcher takes head this cycle
fq_ins  out  32  head instruction
fq_pc  out  32  head pc
fq_pred_taken  out  1  head predicted taken (JAL=1, JALR=0)
fq_count  out  FQ_DEPTH_LOG+1  occupancy
clear  in  1  ROB misprediction flush
new_pc  in  32  redirect target
upt_en  in  1  BHT training strobe
upt_pc  in  32  pc of the resolved branch
upt_taken  in  1  resolved outcome

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC; FQ head/tail/count=0; jalr_wait=0; all BHT counters=BHT_INIT.
- Reset outputs: fq_valid=0, fq_count=0, addr_to_icache=RESET_PC. fq_ins/fq_pc/fq_pred_taken are don't-care while fq_valid=0.
- rst has priority over rdy.
- rdy=0: no state changes, including BHT updates.
- Priority with rdy=1: clear > fetch/dequeue.
- clear: pc<=new_pc; FQ flushed (head=tail=count=0); jalr_wait<=0. Enqueue and dequeue in the same cycle are discarded. A BHT update in the same cycle is still applied.
- deq = fq_valid && fq_ready. Head pointer advances mod depth.
- enq = hit && !jalr_wait && (count < DEPTH || deq). Enqueue into a full FQ is allowed only with a simultaneous dequeue.
- On enq, the entry is written at tail and tail advances mod depth. count <= count + enq - deq.
- Next pc on enq, decoded from ins[6:0]:
  - 1101111 JAL: pc + sext(imm_J); pred=1.
  - 1100011 branch: if BHT[idx(pc)][1]=1 then pc + sext(imm_B) with pred=1, else pc+4 with pred=0.
  - 1100111 JALR: pc+4; pred=0; jalr_wait<=1, so fetch stalls until clear.
  - Any other opcode: pc+4, pred=0.
- No enq: pc holds.
- Latency: a word hit at cycle N is visible on fq_* at N+1 if the FQ was empty. Head outputs are read combinationally from FQ storage.
- All address arithmetic is 32-bit modulo 2^32.
- BHT update: idx = upt_pc[BHT_IDX_W+1:2]. upt_taken=1 increments, saturating at 3; 0 decrements, saturating at 0.
- Update and lookup at the same index in the same cycle: the lookup sees the pre-update value.
- fq_count is registered.

Decomposition:
- Shared package holds:
  - opcode constants OPC_JAL=7'b1101111, OPC_JALR=7'b1100111, OPC_BRANCH=7'b1100011
  - counter width 2 and the saturation limits
  - imm_J / imm_B extraction functions
- One sub-module is natural: fetch_bht (counter array with lookup port and update port, parametrised by BHT_IDX_W and BHT_INIT).
- The FQ stays inline.

Test Plan:
- Reset, hit=1 with ADDI words, fq_ready=0 → FQ entries pc 0x0, 0x4, 0x8; fq_count=3; addr_to_icache=0xC.
- Branch at 0x10, imm_B=+0x20, default BHT → fq_pred_taken=1, next addr 0x30. Then two upt_en at 0x10 with upt_taken=0 (counter 2→0). Redirect to 0x10 → pred=0, next addr 0x14.
- Three taken updates from counter 2 → saturates at 3. Four not-taken updates → saturates at 0; predictions match.
- FQ fill: fq_ready=0, hit=1 → count=8, pc frozen. Then fq_ready=1, hit=1 → count stays 8, order preserved, pc advances by 4 per cycle.
- JALR at 0x40 → enqueued with pred=0; addr stays 0x44 with no enqueues despite hit. clear with new_pc=0x100 → next cycle fq_valid=0, count=0, addr=0x100, fetch resumes.
- Full FQ, clear=1, fq_ready=1, hit=1 and rdy=1 in the same cycle → count=0, nothing enqueued. Then rdy=0 for 3 cycles with hit=1 and upt_en=1 → pc, FQ and BHT unchanged.

Source files
------------

// File: rtl/fetch_unit_q_pkg.sv
// fetch_unit_q_pkg: opcode constants, BHT counter limits and RISC-V immediate helpers.
package fetch_unit_q_pkg;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int CNT_W = 2;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = 2'd3;
  localparam cnt_t CNT_MIN = 2'd0;
  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_unit_q_if.sv
// fetch_unit_q_if: icache, fetch-queue and ROB redirect/training signals of the fetch stage.
interface fetch_unit_q_if #(parameter int FQ_DEPTH_LOG = 3);
  logic hit;
  logic [31:0] ins;
  logic [31:0] addr_to_icache;
  logic fq_valid;
  logic fq_ready;
  logic [31:0] fq_ins;
  logic [31:0] fq_pc;
  logic fq_pred_taken;
  logic [FQ_DEPTH_LOG:0] fq_count;
  logic clear;
  logic [31:0] new_pc;
  logic upt_en;
  logic [31:0] upt_pc;
  logic upt_taken;
  modport master (
    input hit, ins, fq_ready, clear, new_pc, upt_en, upt_pc, upt_taken,
    output addr_to_icache, fq_valid, fq_ins, fq_pc, fq_pred_taken, fq_count
  );
  modport slave (
    output hit, ins, fq_ready, clear, new_pc, upt_en, upt_pc, upt_taken,
    input addr_to_icache, fq_valid, fq_ins, fq_pc, fq_pred_taken, fq_count
  );
endinterface

// File: rtl/fetch_unit_q_bht.sv
// fetch_bht: saturating 2-bit branch history table with one lookup and one update port.
module fetch_bht
  import fetch_unit_q_pkg::*;
#(
  parameter int BHT_IDX_W = 5,
  parameter cnt_t BHT_INIT = 2'b10
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic [BHT_IDX_W-1:0] lk_idx,
  output logic lk_taken,
  input  logic upt_en,
  input  logic [BHT_IDX_W-1:0] upt_idx,
  input  logic upt_taken
);
  localparam int N = 1 << BHT_IDX_W;
  cnt_t cnt [N];
  cnt_t cur;
  cnt_t nxt;
  always_comb begin
    cur = cnt[upt_idx];
    nxt = upt_taken ? (cur == CNT_MAX ? cur : cur + 1'b1) : (cur == CNT_MIN ? cur : cur - 1'b1);
    lk_taken = cnt[lk_idx][CNT_W-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt[i] <= BHT_INIT;
    end else if (rdy && upt_en) begin
      cnt[upt_idx] <= nxt;
    end
  end
endmodule

// File: rtl/fetch_unit_q.sv
// fetch_unit_q: fetch stage with BHT-driven next-pc prediction and a decoupling fetch queue.
module fetch_unit_q
  import fetch_unit_q_pkg::*;
#(
  parameter int BHT_IDX_W = 5,
  parameter int FQ_DEPTH_LOG = 3,
  parameter cnt_t BHT_INIT = 2'b10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  fetch_unit_q_if.master bus
);
  localparam int N = 1 << FQ_DEPTH_LOG;
  localparam logic [FQ_DEPTH_LOG:0] DEPTH = {1'b1, {FQ_DEPTH_LOG{1'b0}}};
  logic [31:0] pc;
  logic jalr_wait;
  logic [FQ_DEPTH_LOG-1:0] head, tail;
  logic [FQ_DEPTH_LOG:0] count;
  logic [31:0] q_ins [N];
  logic [31:0] q_pc [N];
  logic q_pred [N];
  logic bht_taken;
  logic [6:0] opc;
  logic pred;
  logic [31:0] npc;
  logic deq, enq;
  logic unused_upt_bits;
  fetch_bht #(.BHT_IDX_W(BHT_IDX_W), .BHT_INIT(BHT_INIT)) u_bht (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .lk_idx(pc[BHT_IDX_W+1:2]),
    .lk_taken(bht_taken),
    .upt_en(bus.upt_en),
    .upt_idx(bus.upt_pc[BHT_IDX_W+1:2]),
    .upt_taken(bus.upt_taken)
  );
  always_comb begin
    opc = bus.ins[6:0];
    pred = opc == OPC_JAL || (opc == OPC_BRANCH && bht_taken);
    npc = pred ? pc + (opc == OPC_JAL ? imm_j(bus.ins) : imm_b(bus.ins)) : pc + 32'd4;
    deq = bus.fq_valid && bus.fq_ready;
    enq = bus.hit && !jalr_wait && (count != DEPTH || deq);
    unused_upt_bits = ^{bus.upt_pc[31:BHT_IDX_W+2], bus.upt_pc[1:0]};
  end
  assign bus.addr_to_icache = pc;
  assign bus.fq_valid = count != '0;
  assign bus.fq_count = count;
  assign bus.fq_ins = q_ins[head];
  assign bus.fq_pc = q_pc[head];
  assign bus.fq_pred_taken = q_pred[head];
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      jalr_wait <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      if (bus.clear) begin
        pc <= bus.new_pc;
        jalr_wait <= 1'b0;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          pc <= npc;
          tail <= tail + 1'b1;
          jalr_wait <= opc == OPC_JALR;
        end
        if (deq) head <= head + 1'b1;
        count <= count + {{FQ_DEPTH_LOG{1'b0}}, enq} - {{FQ_DEPTH_LOG{1'b0}}, deq};
      end
    end
  end
  // Queue storage needs no reset: entries are only observed behind count.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !bus.clear && enq) begin
      q_ins[tail] <= bus.ins;
      q_pc[tail] <= pc;
      q_pred[tail] <= pred;
    end
  end
endmodule
